// File: rtl/vga_source_arbiter.sv
// rtl/vga_source_arbiter.sv - frame-boundary round-robin arbiter driving the VGA DAC
module vga_source_arbiter #(
    parameter int N_REQ      = 2,
    parameter int MIN_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 display_en,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   pix_in,
    output logic [3:0]           R,
    output logic [3:0]           G,
    output logic [3:0]           B,
    output logic [N_REQ-1:0]     gnt,
    output logic                 owner_valid,
    output logic                 switch_p
);

    localparam int         PW        = (N_REQ > 2) ? 2 : 1;
    localparam logic [7:0] HOLD_LAST = 8'(MIN_FRAMES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [PW-1:0]      r_rr_ptr, w_rr_nxt;
    logic [7:0]         r_frame_cnt, w_cnt_nxt;
    logic               r_switch_p, w_switch_nxt;
    logic [3:0]         r_R, r_G, r_B;

    logic [N_REQ-1:0]   w_others;
    logic               w_owner_req;
    logic [N_REQ-1:0]   w_pick_all;
    logic [N_REQ-1:0]   w_pick_oth;
    logic               w_do_grant;
    logic [N_REQ-1:0]   w_grant_vec;
    logic [5:0]         w_pix;

    // One-hot of the first set bit in mask at or after ptr, wrapping around.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [PW-1:0]    ptr);
        logic [N_REQ-1:0] onehot;
        logic             found;
        logic [PW-1:0]    idx;
        onehot = '0;
        found  = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = PW'((int'(ptr) + off) % N_REQ);
            if (!found && mask[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

    // Pointer that follows the granted source so it gets lowest priority next time.
    function automatic logic [PW-1:0] ptr_after(input logic [N_REQ-1:0] onehot);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (onehot[i]) begin
                p = PW'((i + 1) % N_REQ);
            end
        end
        return p;
    endfunction

    assign w_others    = req & ~r_gnt;
    assign w_owner_req = |(req & r_gnt);
    assign w_pick_all  = rr_pick(req, r_rr_ptr);
    assign w_pick_oth  = rr_pick(w_others, r_rr_ptr);

    // Next-state decision, evaluated only at frame boundaries so ownership never tears a frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_rr_nxt     = r_rr_ptr;
        w_cnt_nxt    = r_frame_cnt;
        w_switch_nxt = 1'b0;
        w_do_grant   = 1'b0;
        w_grant_vec  = '0;
        if (frame_start) begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        w_do_grant  = 1'b1;
                        w_grant_vec = w_pick_all;
                    end
                end
                ST_OWN: begin
                    if (!w_owner_req && (w_others == '0)) begin
                        w_state_nxt  = ST_IDLE;
                        w_gnt_nxt    = '0;
                        w_switch_nxt = 1'b1;
                    end else if (!w_owner_req) begin
                        w_do_grant  = 1'b1;
                        w_grant_vec = w_pick_oth;
                    end else if ((w_others != '0) && (r_frame_cnt >= HOLD_LAST)) begin
                        w_do_grant  = 1'b1;
                        w_grant_vec = w_pick_oth;
                    end else if (r_frame_cnt != 8'hFF) begin
                        w_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
            if (w_do_grant) begin
                w_state_nxt  = ST_OWN;
                w_gnt_nxt    = w_grant_vec;
                w_rr_nxt     = ptr_after(w_grant_vec);
                w_cnt_nxt    = 8'd0;
                w_switch_nxt = (w_grant_vec != r_gnt);
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_frame_cnt <= 8'd0;
            r_switch_p  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_switch_p  <= w_switch_nxt;
        end
    end

    // Select the current owner's pixel; gnt is one-hot so at most one term is taken.
    always_comb begin
        w_pix = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_pix = pix_in[6*i +: 6];
            end
        end
    end

    // Registered DAC drive: 2-bit channels widened by replication, black outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_R <= 4'd0;
            r_G <= 4'd0;
            r_B <= 4'd0;
        end else if (display_en && (|r_gnt)) begin
            r_R <= {w_pix[5:4], w_pix[5:4]};
            r_G <= {w_pix[3:2], w_pix[3:2]};
            r_B <= {w_pix[1:0], w_pix[1:0]};
        end else begin
            r_R <= 4'd0;
            r_G <= 4'd0;
            r_B <= 4'd0;
        end
    end

    assign R           = r_R;
    assign G           = r_G;
    assign B           = r_B;
    assign gnt         = r_gnt;
    assign owner_valid = |r_gnt;
    assign switch_p    = r_switch_p;

endmodule

// File: tb/tb_vga_source_arbiter.sv
// tb/tb_vga_source_arbiter.sv - directed and randomized checks of vga_source_arbiter
module tb_vga_source_arbiter;

    localparam int N    = 2;
    localparam int MINF = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_start;
    logic           display_en;
    logic [N-1:0]   req;
    logic [6*N-1:0] pix_in;
    logic [3:0]     R, G, B;
    logic [N-1:0]   gnt;
    logic           owner_valid;
    logic           switch_p;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = none), rotation start, frames held.
    int m_owner = -1;
    int m_rr    = 0;
    int m_cnt   = 0;
    int m_sw    = 0;
    int m_r = 0, m_g = 0, m_b = 0;

    vga_source_arbiter #(.N_REQ(N), .MIN_FRAMES(MINF)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .display_en  (display_en),
        .req         (req),
        .pix_in      (pix_in),
        .R           (R),
        .G           (G),
        .B           (B),
        .gnt         (gnt),
        .owner_valid (owner_valid),
        .switch_p    (switch_p)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int mask, input int start);
        for (int off = 0; off < N; off++) begin
            if (mask[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    // Advance one clock: predict from pre-edge inputs, then compare after the edge.
    task automatic step();
        int n_owner, n_rr, n_cnt, n_sw, n_r, n_g, n_b, p, k, mreq, others;
        n_owner = m_owner; n_rr = m_rr; n_cnt = m_cnt; n_sw = 0;
        n_r = 0; n_g = 0; n_b = 0;
        mreq = int'(req);
        k = -1;
        if (!rst && display_en && m_owner >= 0) begin
            p   = int'((pix_in >> (6 * m_owner)) & 12'h3F);
            n_r = ((p >> 4) & 3) * 5;
            n_g = ((p >> 2) & 3) * 5;
            n_b = (p & 3) * 5;
        end
        if (rst) begin
            n_owner = -1; n_rr = 0; n_cnt = 0; n_sw = 0;
        end else if (frame_start) begin
            if (m_owner < 0) begin
                if (mreq != 0) k = pick(mreq, m_rr);
            end else begin
                others = mreq & ~(1 << m_owner);
                if (!mreq[m_owner] && others == 0) begin
                    n_owner = -1; n_sw = 1;
                end else if (!mreq[m_owner]) begin
                    k = pick(others, m_rr);
                end else if (others != 0 && m_cnt >= MINF - 1) begin
                    k = pick(others, m_rr);
                end else begin
                    n_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
            if (k >= 0) begin
                n_sw = (k != m_owner) ? 1 : 0;
                n_owner = k; n_rr = (k + 1) % N; n_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_rr = n_rr; m_cnt = n_cnt; m_sw = n_sw;
        m_r = n_r; m_g = n_g; m_b = n_b;
        check("gnt",         32'(gnt),         (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        check("owner_valid", 32'(owner_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        check("switch_p",    32'(switch_p),    32'(m_sw));
        check("R",           32'(R),           32'(m_r));
        check("G",           32'(G),           32'(m_g));
        check("B",           32'(B),           32'(m_b));
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        // Reset held with requests and frame_start asserted
        rst = 1'b1; req = 2'b11; frame_start = 1'b1; display_en = 1'b1; pix_in = '1;
        repeat (3) begin
            step();
            check("t1_gnt", 32'(gnt), 32'd0);
            check("t1_sw",  32'(switch_p), 32'd0);
        end
        rst = 1'b0; frame_start = 1'b0; req = 2'b01;
        step();

        // First grant and pixel latency
        frame();
        check("t2_gnt", 32'(gnt), 32'd1);
        check("t2_sw",  32'(switch_p), 32'd1);
        pix_in = {6'h00, 6'b10_01_11}; display_en = 1'b1;
        step();
        check("t2_R", 32'(R), 32'hA);
        check("t2_G", 32'(G), 32'h5);
        check("t2_B", 32'(B), 32'hF);
        check("t2_sw_low", 32'(switch_p), 32'd0);

        // Minimum hold with both requesting
        req = 2'b11;
        for (int f = 1; f <= 4; f++) begin
            repeat (3) step();
            frame();
            check("t3_gnt", 32'(gnt), (f < 4) ? 32'd1 : 32'd2);
        end
        check("t3_sw", 32'(switch_p), 32'd1);

        // Owner 1 releases to source 0 immediately
        req = 2'b01;
        repeat (2) step();
        frame();
        check("t4_pre_gnt", 32'(gnt), 32'd1);
        req = 2'b11;
        frame();
        repeat (2) step();
        req = 2'b10;
        repeat (3) step();
        check("t4_mid_gnt", 32'(gnt), 32'd1);
        frame();
        check("t4_gnt", 32'(gnt), 32'd2);

        // All requests drop
        req = 2'b00; display_en = 1'b1; pix_in = '1;
        step();
        frame();
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_ov",  32'(owner_valid), 32'd0);
        check("t5_sw",  32'(switch_p), 32'd1);
        step();
        check("t5_R", 32'(R), 32'd0);

        // Blanking while owned
        req = 2'b01;
        frame();
        display_en = 1'b0;
        step();
        check("t6_R_blank", 32'(R), 32'd0);
        display_en = 1'b1;
        step();
        check("t6_R", 32'(R), 32'hF);
        check("t6_B", 32'(B), 32'hF);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            display_en  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            pix_in      = (6*N)'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
